// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Stalls the pipeline while iterating; annul aborts without touching the results.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  annul,
  output logic                  div_stall,
  output logic                  div_valid,
  output logic [DATA_WIDTH-1:0] lo_div_out,
  output logic [DATA_WIDTH-1:0] hi_div_out
);

  // state | meaning
  // IDLE  | waiting for start
  // BUSY  | one quotient bit per cycle, MSB first
  // DONE  | results loaded, div_valid pulse
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic                  r_neg_q;
  logic                  r_neg_r;

  logic                  w_go;
  logic                  w_b_zero;
  logic                  w_last;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic [DATA_WIDTH:0]   w_rem_shift;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_q_next;

  assign w_go     = start & ~annul;
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign w_a_neg  = signed_div & a[DATA_WIDTH-1];
  assign w_b_neg  = signed_div & b[DATA_WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Partial remainder is one bit wider than the operands so the trial borrow is visible.
  assign w_rem_shift = {r_rem, r_q[DATA_WIDTH-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_divisor};
  assign w_qbit      = ~w_trial[DATA_WIDTH];
  assign w_rem_next  = w_qbit ? w_trial[DATA_WIDTH-1:0] : w_rem_shift[DATA_WIDTH-1:0];
  assign w_q_next    = {r_q[DATA_WIDTH-2:0], w_qbit};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_go) w_state_next = w_b_zero ? DONE : BUSY;
      BUSY: if (w_last) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (annul) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      lo_div_out <= '0;
      hi_div_out <= '0;
    end else if (annul) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_q       <= w_a_mag;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            // Divide by zero skips iteration and reports the raw dividend.
            if (w_b_zero) begin
              lo_div_out <= '1;
              hi_div_out <= a;
            end
          end
        end
        BUSY: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt      <= '0;
            lo_div_out <= r_neg_q ? -w_q_next : w_q_next;
            hi_div_out <= r_neg_r ? -w_rem_next : w_rem_next;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign div_stall = ((r_state == IDLE) & w_go) | (r_state == BUSY);
  assign div_valid = (r_state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic        div_stall, div_valid;
  logic [31:0] lo_div_out, hi_div_out;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul),
    .div_stall(div_stall), .div_valid(div_valid),
    .lo_div_out(lo_div_out), .hi_div_out(hi_div_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = '1;
      r = x;
    end else if (!s) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sx / sy;
      r = sx % sy;
    end
  endfunction

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic si);
    logic [31:0] eq, er;
    int lat, exp_lat;
    bit got, stall_bad;
    model(ai, bi, si, eq, er);
    exp_lat = (bi == 32'd0) ? 1 : 33;
    a = ai; b = bi; signed_div = si; start = 1'b1;
    #1;
    n_checks++;
    if (div_stall !== 1'b1) begin
      n_errs++;
      $display("FAIL stall_cycle0 a=%h b=%h got=%b want=1", ai, bi, div_stall);
    end
    lat = 0; got = 0; stall_bad = 0;
    while (!got && lat < 40) begin
      cyc();
      start = 1'b0;
      a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
      lat++;
      #1;
      if (div_valid === 1'b1) got = 1;
      else if (div_stall !== 1'b1) stall_bad = 1;
    end
    n_checks++;
    if (!got || lat != exp_lat) begin
      n_errs++;
      $display("FAIL latency a=%h b=%h got=%0d want=%0d", ai, bi, got ? lat : -1, exp_lat);
    end
    n_checks++;
    if (stall_bad) begin
      n_errs++;
      $display("FAIL stall_busy a=%h b=%h got=0 want=1 before valid", ai, bi);
    end
    n_checks++;
    if (div_stall !== 1'b0) begin
      n_errs++;
      $display("FAIL stall_done a=%h b=%h got=%b want=0", ai, bi, div_stall);
    end
    n_checks++;
    if (lo_div_out !== eq) begin
      n_errs++;
      $display("FAIL lo a=%h b=%h s=%b got=%h want=%h", ai, bi, si, lo_div_out, eq);
    end
    n_checks++;
    if (hi_div_out !== er) begin
      n_errs++;
      $display("FAIL hi a=%h b=%h s=%b got=%h want=%h", ai, bi, si, hi_div_out, er);
    end
    cyc();
    #1;
    n_checks++;
    if (div_valid !== 1'b0 || lo_div_out !== eq || hi_div_out !== er) begin
      n_errs++;
      $display("FAIL hold a=%h b=%h got=%b/%h/%h want=0/%h/%h", ai, bi,
               div_valid, lo_div_out, hi_div_out, eq, er);
    end
    last_q = eq;
    last_r = er;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if (div_valid !== 1'b0 || div_stall !== 1'b0) begin
      n_errs++;
      $display("FAIL reset_ctrl got valid=%b stall=%b want 0/0", div_valid, div_stall);
    end
    n_checks++;
    if (lo_div_out !== 32'd0 || hi_div_out !== 32'd0) begin
      n_errs++;
      $display("FAIL reset_out got lo=%h hi=%h want 0/0", lo_div_out, hi_div_out);
    end
    cyc();
  endtask

  task automatic test_directed();
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op(32'h1234_5678, 32'd0, 1'b0);
    run_op(32'h8765_4321, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(1, 255);
        1: rb = -$urandom_range(1, 255);
        2: rb = $urandom;
        default: rb = (i % 8 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, 1'b1 & $urandom_range(0, 1));
    end
  endtask

  task automatic test_annul();
    run_op(32'd1000, 32'd7, 1'b0);
    a = 32'd99999; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      start = 1'b0;
    end
    annul = 1'b1;
    cyc();
    annul = 1'b0;
    #1;
    n_checks++;
    if (div_stall !== 1'b0 || div_valid !== 1'b0) begin
      n_errs++;
      $display("FAIL annul_idle got stall=%b valid=%b want 0/0", div_stall, div_valid);
    end
    n_checks++;
    if (lo_div_out !== last_q || hi_div_out !== last_r) begin
      n_errs++;
      $display("FAIL annul_keep got lo=%h hi=%h want %h/%h", lo_div_out, hi_div_out, last_q, last_r);
    end
    run_op(32'd5000, 32'd9, 1'b0);
  endtask

  task automatic test_rst_mid();
    int pulses;
    run_op(32'hDEAD_BEEF, 32'd5, 1'b0);
    a = 32'h0F0F_0F0F; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      start = 1'b0;
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if (div_stall !== 1'b0 || div_valid !== 1'b0) begin
      n_errs++;
      $display("FAIL rst_mid_ctrl got stall=%b valid=%b want 0/0", div_stall, div_valid);
    end
    n_checks++;
    if (lo_div_out !== 32'd0 || hi_div_out !== 32'd0) begin
      n_errs++;
      $display("FAIL rst_mid_out got lo=%h hi=%h want 0/0", lo_div_out, hi_div_out);
    end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      #1;
      if (div_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errs++;
      $display("FAIL rst_mid_pulse got=%0d want=0", pulses);
    end
  endtask

  task automatic test_start_held();
    logic [31:0] eq, er;
    int pulses, first_lat;
    model(32'd123456, 32'd321, 1'b0, eq, er);
    a = 32'd123456; b = 32'd321; signed_div = 1'b0; start = 1'b1;
    pulses = 0; first_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      #1;
      if (div_valid === 1'b1) begin
        pulses++;
        if (first_lat < 0) begin
          first_lat = k;
          n_checks++;
          if (lo_div_out !== eq || hi_div_out !== er) begin
            n_errs++;
            $display("FAIL held_result got lo=%h hi=%h want %h/%h", lo_div_out, hi_div_out, eq, er);
          end
        end
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (pulses != 1 || first_lat != 33) begin
      n_errs++;
      $display("FAIL held_pulses got=%0d@%0d want=1@33", pulses, first_lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_annul();
    test_rst_mid();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
